mult_lastn_seq: RTL and testbench
=================================

// Module: mult_lastn_seq
// PURPOSE
//  Multiplies the last N accepted non-ignored samples of a W-bit input stream.
//  Samples enter through a valid/ready handshake. An iterative multiplier runs one partial product per cycle.
//  Generalises the two-sample multiplier: depth N, valid/ready flow control, full-width product, synchronous ld.
//  Sits between a sample source and a consumer that latches out on out_vld.
// PARAMETERS
//  W    4   sample width in bits (>=1)
//  N    2   window depth: number of samples in the product (>=2)
//  IGN  0   ignore value after reset (W bits)
// PORTS
//  clk      in   1          clock; all state changes on posedge
//  rst      in   1          synchronous reset, active-high
//  in_data  in   W          sample, or new ignore value when ld=1
//  in_vld   in   1          in_data valid
//  in_rdy   out  1          block can accept a sample (high only in IDLE)
//  ld       in   1          with in_vld: load in_data as ignore value
//  out      out  N*W        product of the last N samples
//  out_vld  out  1          1-cycle pulse: out was updated at this edge
//  full     out  1          window holds N real samples
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - win[0..N-1] cleared to 0; fill cleared to 0; out cleared to 0; out_vld cleared to 0.
//   - ign_reg set to IGN; state set to IDLE. Reset aborts a CALC in progress.
//  Ignore-value load:
//   - ld & in_vld at a posedge sets ign_reg <= in_data, in any state.
//   - The sample is not pushed. A CALC in progress is unaffected.
//   - ld has priority over sample accept.
//  Sample accept:
//   - A sample is accepted when in_vld & in_rdy & !ld.
//   - If in_data == ign_reg (value before any load this edge), the sample is consumed and discarded.
//     No window change, no CALC, out and out_vld unchanged.
//   - Otherwise the window shifts: win[0] <= in_data, win[i] <= win[i-1].
//   - fill increments and saturates at N; full = (fill == N).
//  FSM:
//   - IDLE: in_rdy=1. On a non-ignored accept: acc <= in_data, idx <= 1, go to CALC.
//   - CALC: in_rdy=0. Each cycle acc <= acc * win[idx], idx++. Widths: N*W, so no overflow.
//   - When idx == N-1: out <= acc*win[N-1], out_vld <= 1, go to IDLE.
//  Latency: accept at edge k; out and out_vld valid after edge k+N-1. in_rdy is low for N-1 cycles.
//  Empty window slots are 0, so out = 0 until N samples have arrived (out_vld still pulses).
//  Back-to-back: the first cycle after out_vld is IDLE, so the next sample is accepted.
//  in_vld with in_rdy=0: no effect; the source must hold the sample.
// STRUCTURE
//  mult_pkg.vh: state encodings (S_IDLE, S_CALC), clog2 helper for the fill and idx widths.
//  Sub-module mult_window #(W,N): shift register with shift enable, clear, and indexed read port win[idx].
//  Top level contains the FSM, acc, ign_reg, fill, and output registers.
// TESTING
//  1) N=2, W=4, IGN=0. Send 5, then 10.
//     -> out=0 after the first sample and out=50 after the second, each with an out_vld pulse.
//     -> in_rdy is low for exactly 1 cycle per sample.
//  2) Ignore: after (1), send 0.
//     -> consumed, in_rdy stays high, no out_vld, out stays 50.
//     Then send 5 -> out=50*5/10 window = 5*10 = 50.
//     Then send 2 -> out=10.
//  3) Load: ld=1 with in_data=10. Then send 10 -> ignored.
//     Then send 13 -> out=26 (window 2,13).
//     Then send 0 -> accepted, out=0, because 0 is no longer the ignore value.
//  4) N=3, W=4. Send 15, 15, 15.
//     -> final out=3375 (12 bits) 2 edges after the third accept; full=1.
//  5) Reset mid-CALC: assert rst in the cycle after an accept.
//     -> next edge: out=0, out_vld=0, fill=0, in_rdy=1, ign_reg=IGN, no late out_vld pulse.
//  6) W=6, IGN=8, N=2. Send 63, 63 -> out=3969. Send 8 -> ignored, out=3969.

Source files
------------

// File: rtl/mult_lastn_seq_pkg.sv
// Shared state encoding and width helper for the last-N sample multiplier.
package mult_lastn_seq_pkg;

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    // Number of bits needed to hold values 0..v-1 (at least 1).
    function automatic int clog2_f(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_lastn_seq_window.sv
// N-deep sample window: shifts new samples into slot 0 and offers one indexed read port.
module mult_lastn_seq_window
    import mult_lastn_seq_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 2,
    localparam int IW = clog2_f(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          shift,
    input  logic [W-1:0]  din,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);

    logic [N-1:0][W-1:0] win_q;
    logic [N-1:0][W-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (shift) begin
            win_d[0] = din;
            for (int i = 1; i < N; i++) begin
                win_d[i] = win_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    // Compare-based read so non-power-of-two depths never index past the window.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == rd_idx) begin
                rd_data = win_q[i];
            end
        end
    end

endmodule

// File: rtl/mult_lastn_seq.sv
// Multiplies the last N non-ignored samples, one partial product per cycle.
module mult_lastn_seq
    import mult_lastn_seq_pkg::*;
#(
    parameter int          W   = 4,
    parameter int          N   = 2,
    parameter logic [W-1:0] IGN = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic           ld,
    output logic [N*W-1:0] out,
    output logic           out_vld,
    output logic           full
);

    localparam int PW = N * W;
    localparam int IW = clog2_f(N);
    localparam int FW = clog2_f(N + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    ign_q, ign_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   out_q, out_d;
    logic            out_vld_q, out_vld_d;

    logic            accept;
    logic            push;
    logic [W-1:0]    rd_data;
    logic [PW-1:0]   prod;

    assign in_rdy  = (state_q == S_IDLE);
    assign accept  = in_vld & in_rdy & ~ld;
    assign push    = accept & (in_data != ign_q);
    assign prod    = acc_q * {{(PW-W){1'b0}}, rd_data};
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign full    = (fill_q == FW'(N));

    mult_lastn_seq_window #(
        .W (W),
        .N (N)
    ) u_window (
        .clk     (clk),
        .clr     (rst),
        .shift   (push),
        .din     (in_data),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        ign_d     = ign_q;
        fill_d    = fill_q;
        out_d     = out_q;
        out_vld_d = 1'b0;

        if (in_vld && ld) begin
            ign_d = in_data;
        end

        if (push && !full) begin
            fill_d = fill_q + 1'b1;
        end

        // acc starts from the new sample, which is also win[0] after this edge.
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    acc_d   = {{(PW-W){1'b0}}, in_data};
                    idx_d   = IW'(1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (idx_q == IW'(N - 1)) begin
                    out_d     = prod;
                    out_vld_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    acc_d = prod;
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            ign_q     <= IGN;
            fill_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            ign_q     <= ign_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_mult_lastn_seq.sv
// Directed bench for mult_lastn_seq: three instances cover N=2/W=4, N=3/W=4 and N=2/W=6/IGN=8.
module tb_mult_lastn_seq;

    logic clk;
    logic rst;

    logic [3:0]  in_data_a;
    logic        in_vld_a, ld_a, in_rdy_a, out_vld_a, full_a;
    logic [7:0]  out_a;

    logic [3:0]  in_data_b;
    logic        in_vld_b, ld_b, in_rdy_b, out_vld_b, full_b;
    logic [11:0] out_b;

    logic [5:0]  in_data_c;
    logic        in_vld_c, ld_c, in_rdy_c, out_vld_c, full_c;
    logic [11:0] out_c;

    int tests_run;
    int tests_failed;

    mult_lastn_seq #(.W(4), .N(2), .IGN(4'd0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_vld(in_vld_a), .in_rdy(in_rdy_a),
        .ld(ld_a), .out(out_a), .out_vld(out_vld_a), .full(full_a)
    );

    mult_lastn_seq #(.W(4), .N(3), .IGN(4'd0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_vld(in_vld_b), .in_rdy(in_rdy_b),
        .ld(ld_b), .out(out_b), .out_vld(out_vld_b), .full(full_b)
    );

    mult_lastn_seq #(.W(6), .N(2), .IGN(6'd8)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_vld(in_vld_c), .in_rdy(in_rdy_c),
        .ld(ld_c), .out(out_c), .out_vld(out_vld_c), .full(full_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_rdy(input int dut);
        case (dut)
            0: return in_rdy_a;
            1: return in_rdy_b;
            default: return in_rdy_c;
        endcase
    endfunction

    function automatic logic get_vld(input int dut);
        case (dut)
            0: return out_vld_a;
            1: return out_vld_b;
            default: return out_vld_c;
        endcase
    endfunction

    function automatic logic get_full(input int dut);
        case (dut)
            0: return full_a;
            1: return full_b;
            default: return full_c;
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int dut);
        case (dut)
            0: return 32'(out_a);
            1: return 32'(out_b);
            default: return 32'(out_c);
        endcase
    endfunction

    task automatic setInputs(input int dut, input logic [5:0] d, input logic v, input logic l);
        case (dut)
            0: begin in_data_a = d[3:0]; in_vld_a = v; ld_a = l; end
            1: begin in_data_b = d[3:0]; in_vld_b = v; ld_b = l; end
            default: begin in_data_c = d; in_vld_c = v; ld_c = l; end
        endcase
    endtask

    // Holds the sample until in_rdy, then leaves us 1 ns after the accepting edge.
    task automatic applyStimulus(input int dut, input logic [5:0] data, input logic ldv, input string tag);
        int waited;
        waited = 0;
        setInputs(dut, data, 1'b1, ldv);
        if (!ldv) begin
            while (!get_rdy(dut) && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (waited >= 20) checkOutput({tag, "_rdy_timeout"}, 32'(waited), 32'd0);
        end
        @(posedge clk);
        #1;
        setInputs(dut, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic expectResult(input int dut, input string tag, input logic [31:0] exp_out,
                                input int exp_lat, input logic exp_full);
        int cycles;
        logic seen;
        cycles = 0;
        seen = 1'b0;
        checkOutput({tag, "_rdy_busy"}, 32'(get_rdy(dut)), 32'd0);
        while (!seen && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = get_vld(dut);
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        checkOutput({tag, "_out"}, get_out(dut), exp_out);
        checkOutput({tag, "_rdy_back"}, 32'(get_rdy(dut)), 32'd1);
        checkOutput({tag, "_full"}, 32'(get_full(dut)), 32'(exp_full));
        @(posedge clk);
        #1;
        checkOutput({tag, "_vld_pulse"}, 32'(get_vld(dut)), 32'd0);
    endtask

    task automatic expectIgnored(input int dut, input string tag, input logic [31:0] exp_out);
        checkOutput({tag, "_rdy_high"}, 32'(get_rdy(dut)), 32'd1);
        checkOutput({tag, "_no_vld"}, 32'(get_vld(dut)), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_no_vld2"}, 32'(get_vld(dut)), 32'd0);
        checkOutput({tag, "_out_held"}, get_out(dut), exp_out);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) setInputs(d, 6'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rst%0d_out", d), get_out(d), 32'd0);
            checkOutput($sformatf("rst%0d_vld", d), 32'(get_vld(d)), 32'd0);
            checkOutput($sformatf("rst%0d_full", d), 32'(get_full(d)), 32'd0);
            checkOutput($sformatf("rst%0d_rdy", d), 32'(get_rdy(d)), 32'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-sample window, ignore value 0.
        applyStimulus(0, 6'd5, 1'b0, "t1_5");
        expectResult(0, "t1_5", 32'd0, 1, 1'b0);
        applyStimulus(0, 6'd10, 1'b0, "t1_10");
        expectResult(0, "t1_10", 32'd50, 1, 1'b1);

        applyStimulus(0, 6'd0, 1'b0, "t2_0");
        expectIgnored(0, "t2_0", 32'd50);
        applyStimulus(0, 6'd5, 1'b0, "t2_5");
        expectResult(0, "t2_5", 32'd50, 1, 1'b1);
        applyStimulus(0, 6'd2, 1'b0, "t2_2");
        expectResult(0, "t2_2", 32'd10, 1, 1'b1);

        applyStimulus(0, 6'd10, 1'b1, "t3_ld");
        checkOutput("t3_ld_no_vld", 32'(get_vld(0)), 32'd0);
        checkOutput("t3_ld_rdy", 32'(get_rdy(0)), 32'd1);
        applyStimulus(0, 6'd10, 1'b0, "t3_10");
        expectIgnored(0, "t3_10", 32'd10);
        applyStimulus(0, 6'd13, 1'b0, "t3_13");
        expectResult(0, "t3_13", 32'd26, 1, 1'b1);
        applyStimulus(0, 6'd0, 1'b0, "t3_0");
        expectResult(0, "t3_0", 32'd0, 1, 1'b1);

        // Three-deep window: full-width 12-bit product.
        applyStimulus(1, 6'd15, 1'b0, "t4_a");
        expectResult(1, "t4_a", 32'd0, 2, 1'b0);
        applyStimulus(1, 6'd15, 1'b0, "t4_b");
        expectResult(1, "t4_b", 32'd0, 2, 1'b0);
        applyStimulus(1, 6'd15, 1'b0, "t4_c");
        expectResult(1, "t4_c", 32'd3375, 2, 1'b1);

        // Six-bit samples with non-zero ignore value 8.
        applyStimulus(2, 6'd63, 1'b0, "t6_a");
        expectResult(2, "t6_a", 32'd0, 1, 1'b0);
        applyStimulus(2, 6'd63, 1'b0, "t6_b");
        expectResult(2, "t6_b", 32'd3969, 1, 1'b1);
        applyStimulus(2, 6'd8, 1'b0, "t6_8");
        expectIgnored(2, "t6_8", 32'd3969);

        // Reset in the cycle after an accept aborts the calculation.
        applyStimulus(0, 6'd7, 1'b0, "t5_7");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t5_out", get_out(0), 32'd0);
        checkOutput("t5_vld", 32'(get_vld(0)), 32'd0);
        checkOutput("t5_full", 32'(get_full(0)), 32'd0);
        checkOutput("t5_rdy", 32'(get_rdy(0)), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t5_no_late_vld%0d", i), 32'(get_vld(0)), 32'd0);
        end
        applyStimulus(0, 6'd0, 1'b0, "t5_ign0");
        expectIgnored(0, "t5_ign0", 32'd0);
        applyStimulus(0, 6'd3, 1'b0, "t5_3");
        expectResult(0, "t5_3", 32'd0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
